// File: rtl/jtlabrun_rom_fetch_pkg.sv
// Fetch sequencer state encoding for the main-CPU ROM cache.
// No datapath; types only.
// No flow control of its own.
package jtlabrun_rom_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } fetch_state_t;

endpackage

// File: rtl/jtlabrun_rom_tags.sv
// Direct-mapped line store: valid bits, tags and 32-bit data words.
// Async read; write lands on the next clk edge.
// No backpressure; flush/reset clear every valid bit and beat a concurrent write.
module jtlabrun_rom_tags #(
    parameter int TW   = 12,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [TW-1:0]   rd_tag,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TW-1:0]   wr_tag,
    input  logic [31:0]     wr_data
);

    localparam int LINES = 1 << IDXW;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags  [LINES];
    logic [31:0]      words [LINES];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = words[rd_idx];

endmodule

// File: rtl/jtlabrun_rom_fetch.sv
// Byte-wide 6809 ROM port in front of a 32-bit SDRAM slot, with a direct-mapped word cache.
// Hit: cpu_ok 1 clk after cpu_addr settles; miss: one SDRAM word fetch, fill, then hit.
// sdram_req held until sdram_ack; cpu_ok stays low (CPU waits) while a fetch is in flight.
module jtlabrun_rom_fetch
    import jtlabrun_rom_fetch_pkg::*;
#(
    parameter int AW   = 17,
    parameter int IDXW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_cs,
    output logic [7:0]    cpu_data,
    output logic          cpu_ok,
    output logic [AW-3:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [31:0]   sdram_din
);

    localparam int WW = AW - 2;
    localparam int TW = AW - IDXW - 2;

    fetch_state_t state, state_nx;

    logic [IDXW-1:0] cpu_idx;
    logic [TW-1:0]   cpu_tag;
    logic [1:0]      cpu_byte;
    logic            line_valid;
    logic [TW-1:0]   line_tag;
    logic [31:0]     line_data;
    logic [7:0]      line_byte;
    logic            hit;
    logic            hit_take;
    logic            fill_now;
    logic            wr_en;
    logic            drop;
    logic            ok_q;
    logic [AW-1:0]   ok_addr;
    logic [7:0]      data_q;

    assign cpu_idx  = cpu_addr[IDXW+1:2];
    assign cpu_tag  = cpu_addr[AW-1:IDXW+2];
    assign cpu_byte = cpu_addr[1:0];

    jtlabrun_rom_tags #(
        .TW   (TW),
        .IDXW (IDXW)
    ) u_tags (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rd_idx   (cpu_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (sdram_addr[IDXW-1:0]),
        .wr_tag   (sdram_addr[WW-1:IDXW]),
        .wr_data  (sdram_din)
    );

    assign hit      = line_valid && (line_tag == cpu_tag);
    assign hit_take = (state == ST_IDLE) && cpu_cs && hit && !flush;

    // rdy counts in REQ only when it arrives together with the ack.
    assign fill_now = sdram_rdy && ((state == ST_WAIT) || ((state == ST_REQ) && sdram_ack));
    assign wr_en    = fill_now && !drop && !flush;

    always_comb begin
        line_byte = line_data[7:0];
        case (cpu_byte)
            2'd1:    line_byte = line_data[15:8];
            2'd2:    line_byte = line_data[23:16];
            2'd3:    line_byte = line_data[31:24];
            default: line_byte = line_data[7:0];
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cpu_cs && !flush && !hit) state_nx = ST_REQ;
            ST_REQ:  if (sdram_ack) state_nx = sdram_rdy ? ST_FILL : ST_WAIT;
            ST_WAIT: if (sdram_rdy) state_nx = ST_FILL;
            ST_FILL: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            ok_q       <= 1'b0;
            ok_addr    <= '0;
            data_q     <= 8'd0;
            drop       <= 1'b0;
        end else begin
            state <= state_nx;
            ok_q  <= hit_take;
            if (hit_take) begin
                data_q  <= line_byte;
                ok_addr <= cpu_addr;
            end
            if ((state == ST_IDLE) && (state_nx == ST_REQ)) begin
                sdram_req  <= 1'b1;
                sdram_addr <= cpu_addr[AW-1:2];
                drop       <= 1'b0;
            end else if ((state == ST_REQ) && sdram_ack) begin
                sdram_req <= 1'b0;
            end
            // A flush while the word is in flight makes it stale: finish the handshake, skip the fill.
            if (flush && ((state == ST_REQ) || (state == ST_WAIT))) begin
                drop <= 1'b1;
            end
        end
    end

    // Registered hit is only reported while the CPU still presents that exact address.
    assign cpu_ok   = ok_q && cpu_cs && !flush && (cpu_addr == ok_addr);
    assign cpu_data = data_q;

endmodule

// File: tb/tb_jtlabrun_rom_fetch.sv
// Directed scenarios plus a random soak of jtlabrun_rom_fetch against a flat ROM model.
// A random-latency SDRAM responder answers requests during the soak.
module tb_jtlabrun_rom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [16:0] cpu_addr;
    logic        cpu_cs;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic [14:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [31:0] sdram_din;

    int checks = 0;
    int errors = 0;

    logic        resp_auto = 1'b0;
    int          rs = 0;
    int          rcnt = 0;
    logic [14:0] rword;
    logic [14:0] exp_word;

    always #5 clk = ~clk;

    jtlabrun_rom_fetch #(.AW(17), .IDXW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cpu_addr   (cpu_addr),
        .cpu_cs     (cpu_cs),
        .cpu_data   (cpu_data),
        .cpu_ok     (cpu_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din)
    );

    // ROM contents: one fixed word for the directed cases, arithmetic pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [14:0] w);
        if (w == 15'h2000) return 32'hDDCCBBAA;
        return {w[7:0] ^ 8'h3C, w[14:8], 1'b1, ~w[7:0], w[14:7] + 8'h11};
    endfunction

    function automatic logic [7:0] rom_byte(input logic [16:0] a);
        logic [31:0] w;
        w = rom_word(a[16:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (resp_auto) begin
            if (rs == 2) begin
                rcnt--;
                if (rcnt == 0) begin
                    sdram_rdy = 1'b1;
                    sdram_din = rom_word(rword);
                    rs = 0;
                end
            end
            if (rs == 0 && sdram_req) begin
                check("req_addr", sdram_addr, exp_word);
                rword = sdram_addr;
                rcnt  = $urandom_range(0, 19);
                rs    = 1;
            end
            if (rs == 1) begin
                if (rcnt == 0) begin
                    sdram_ack = 1'b1;
                    rcnt = $urandom_range(0, 19);
                    if (rcnt == 0) begin
                        sdram_rdy = 1'b1;
                        sdram_din = rom_word(rword);
                        rs = 0;
                    end else begin
                        rs = 2;
                    end
                end else begin
                    rcnt--;
                end
            end
        end
    endtask

    task automatic wait_ok(input int budget, input string tag);
        int c;
        c = 0;
        #1;
        while (cpu_ok !== 1'b1 && c < budget) begin
            cycle();
            #1;
            c++;
        end
        check(tag, cpu_ok, 1);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int c;
        c = 0;
        #1;
        while (sdram_req !== 1'b1 && c < budget) begin
            cycle();
            #1;
            c++;
        end
        check(tag, sdram_req, 1);
    endtask

    // Manual handshake: ack now, rdy after gap extra clocks with the model word.
    task automatic serve(input int gap);
        sdram_ack = 1'b1;
        cycle();
        repeat (gap) cycle();
        sdram_rdy = 1'b1;
        sdram_din = rom_word(sdram_addr);
    endtask

    logic [11:0] tagpool [4] = '{12'h000, 12'h400, 12'hFFF, 12'h5A3};

    initial begin
        logic [16:0] a;
        logic [16:0] prev;

        rst = 1'b1; flush = 1'b0; cpu_addr = '0; cpu_cs = 1'b0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        prev = '0;
        repeat (3) cycle();
        #1;
        check("rst_ok", cpu_ok, 0);
        check("rst_data", cpu_data, 0);
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);

        // Cold miss
        rst = 1'b0; cpu_addr = 17'h08001; cpu_cs = 1'b1;
        #1; check("cold_ok_before", cpu_ok, 0);
        cycle(); #1;
        check("cold_req", sdram_req, 1);
        check("cold_addr", sdram_addr, 15'h2000);
        cycle(); #1;
        check("cold_req_held", sdram_req, 1);
        check("cold_addr_held", sdram_addr, 15'h2000);
        sdram_ack = 1'b1;
        cycle(); #1;
        check("cold_req_drop", sdram_req, 0);
        sdram_rdy = 1'b1; sdram_din = 32'hDDCCBBAA;
        wait_ok(6, "cold_ok");
        check("cold_data", cpu_data, 8'hBB);

        // Hit on another byte of the same word
        cpu_addr = 17'h08003;
        #1; check("hit_ok_drop", cpu_ok, 0);
        cycle(); #1;
        check("hit_ok", cpu_ok, 1);
        check("hit_data", cpu_data, 8'hDD);
        check("hit_noreq", sdram_req, 0);

        // Conflict: same index, other tag; ack and rdy together
        cpu_addr = 17'h08021;
        cycle(); #1;
        check("conf_req", sdram_req, 1);
        check("conf_addr", sdram_addr, 15'h2008);
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = rom_word(15'h2008);
        wait_ok(6, "conf_ok");
        check("conf_data", cpu_data, rom_byte(17'h08021));
        cpu_addr = 17'h08001;
        cycle(); #1;
        check("reconf_req", sdram_req, 1);
        check("reconf_addr", sdram_addr, 15'h2000);
        serve(1);
        wait_ok(6, "reconf_ok");
        check("reconf_data", cpu_data, 8'hBB);

        // Address change while waiting for data
        cpu_addr = 17'h04004;
        cycle(); #1;
        check("mw_addr", sdram_addr, 15'h1001);
        sdram_ack = 1'b1;
        cycle(); cycle();
        cpu_addr = 17'h0C000;
        #1; check("mw_ok_stale", cpu_ok, 0);
        sdram_rdy = 1'b1; sdram_din = rom_word(15'h1001);
        for (int c = 0; c < 8 && sdram_req !== 1'b1; c++) begin
            cycle(); #1;
            check("mw_no_ok", cpu_ok, 0);
        end
        check("mw_req2", sdram_req, 1);
        check("mw_addr2", sdram_addr, 15'h3000);
        serve(2);
        wait_ok(6, "mw_ok2");
        check("mw_data2", cpu_data, rom_byte(17'h0C000));
        cpu_addr = 17'h04004;
        cycle(); #1;
        check("mw_first_filled", cpu_ok, 1);
        check("mw_first_data", cpu_data, rom_byte(17'h04004));
        check("mw_first_noreq", sdram_req, 0);

        // Flush while waiting: fill must be discarded
        cpu_addr = 17'h08005;
        cycle(); #1;
        check("fl_addr", sdram_addr, 15'h2001);
        sdram_ack = 1'b1;
        cycle();
        flush = 1'b1;
        #1; check("fl_ok_low", cpu_ok, 0);
        cycle();
        flush = 1'b0; sdram_rdy = 1'b1; sdram_din = rom_word(15'h2001);
        wait_req(6, "fl_rereq");
        check("fl_readdr", sdram_addr, 15'h2001);
        serve(0);
        wait_ok(6, "fl_ok");
        check("fl_data", cpu_data, rom_byte(17'h08005));
        flush = 1'b1;
        #1; check("fl_hit_masked", cpu_ok, 0);
        cycle();
        flush = 1'b0; cpu_addr = 17'h08001;
        cycle(); #1;
        check("fl_clears_all", sdram_req, 1);

        // Reset with a request pending, then stray handshake pulses
        rst = 1'b1; cpu_cs = 1'b0;
        cycle(); #1;
        check("rst_mid_req", sdram_req, 0);
        rst = 1'b0; sdram_ack = 1'b1;
        cycle();
        sdram_rdy = 1'b1; sdram_din = 32'hFFFFFFFF;
        cycle(); cycle(); #1;
        check("late_req", sdram_req, 0);
        check("late_ok", cpu_ok, 0);
        cpu_cs = 1'b1;
        wait_req(4, "post_rst_req");
        check("post_rst_addr", sdram_addr, 15'h2000);
        serve(1);
        wait_ok(6, "post_rst_ok");
        check("post_rst_data", cpu_data, 8'hBB);

        // Random soak with random-latency responder
        resp_auto = 1'b1; rs = 0;
        cycle();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cpu_cs = 1'b0;
                #1; check("soak_ok_no_cs", cpu_ok, 0);
                cycle();
            end
            if (n > 0 && $urandom_range(0, 1) == 1)
                a = {prev[16:2], 2'($urandom_range(0, 3))};
            else
                a = {tagpool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            cpu_addr = a; cpu_cs = 1'b1; exp_word = a[16:2];
            wait_ok(60, "soak_ok");
            check("soak_data", cpu_data, rom_byte(a));
            prev = a;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
